// File: rtl/rcv_ctrl_timer_pkg.sv
// Shared types and default constants for the UART receive control path.
// Imported by the receive timer top and its bench.
package rcv_pkg;

    localparam int CLKS_PER_BIT_DEF = 10;
    localparam int DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } rcv_state_t;

endpackage

// File: rtl/rcv_ctrl_timer_if.sv
// Serial-in / strobe-out bundle of the receive control timer.
// The timer drives the slave side, the line source the master side.
interface rcv_ctrl_timer_if;

    logic serial_in;
    logic shift_enable;
    logic load_buffer;
    logic framing_error;
    logic busy;

    modport slave (
        input  serial_in,
        output shift_enable,
        output load_buffer,
        output framing_error,
        output busy
    );

    modport master (
        output serial_in,
        input  shift_enable,
        input  load_buffer,
        input  framing_error,
        input  busy
    );

endinterface

// File: rtl/flex_counter.sv
// Clearable up-counter that wraps to 0 after reaching rollover_val.
// rollover_flag is registered and high while count_out == rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] cnt_n;
    logic                    flag_n;

    // Next count: clear wins, otherwise increment and wrap at rollover_val
    always_comb begin
        cnt_n = count_out;
        if (clear) begin
            cnt_n = '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                cnt_n = '0;
            end else begin
                cnt_n = count_out + 1'b1;
            end
        end
        flag_n = (cnt_n == rollover_val);
    end

    // Count and flag registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= cnt_n;
            rollover_flag <= flag_n;
        end
    end

endmodule

// File: rtl/rcv_ctrl_timer.sv
// UART receive control: start detect, mid-bit shift strobes,
// stop-bit check with load strobe or sticky framing error.
module rcv_ctrl_timer
    import rcv_pkg::*;
#(
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
    parameter int NUM_DATA_BITS = DATA_BITS_DEF
) (
    input  logic          clk,
    input  logic          n_rst,
    rcv_ctrl_timer_if.slave rx
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(NUM_DATA_BITS + 1);

    localparam logic [TW-1:0] T_ROLL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_MID  = TW'(HALF - 1);
    localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] B_ROLL = BW'(NUM_DATA_BITS);

    rcv_state_t    state, state_n;
    logic          prev;
    logic          start_edge;
    logic [TW-1:0] t_cnt;
    logic          t_flag;
    logic          t_clr, t_en;
    logic [BW-1:0] b_cnt;
    logic          b_flag;
    logic          b_clr, b_en;
    logic          se_n, lb_n, fe_n, busy_n;

    assign start_edge = prev & ~rx.serial_in;

    flex_counter #(.NUM_CNT_BITS(TW)) u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (t_clr),
        .count_enable (t_en),
        .rollover_val (T_ROLL),
        .count_out    (t_cnt),
        .rollover_flag(t_flag)
    );

    flex_counter #(.NUM_CNT_BITS(BW)) u_bits (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (b_clr),
        .count_enable (b_en),
        .rollover_val (B_ROLL),
        .count_out    (b_cnt),
        .rollover_flag(b_flag)
    );

    // Next state and next registered outputs; strobes are decided one
    // cycle early so they land on the mid-bit cycle after registering
    always_comb begin
        state_n = state;
        se_n    = 1'b0;
        lb_n    = 1'b0;
        fe_n    = rx.framing_error;
        t_clr   = 1'b0;
        t_en    = 1'b0;
        b_clr   = 1'b0;
        b_en    = 1'b0;
        unique case (state)
            IDLE: begin
                t_clr = 1'b1;
                b_clr = 1'b1;
                if (start_edge) begin
                    state_n = START;
                end
            end
            START: begin
                t_en  = 1'b1;
                b_clr = 1'b1;
                if (t_cnt == T_MID) begin
                    if (!rx.serial_in) begin
                        state_n = DATA;
                        t_clr   = 1'b1;
                        fe_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                t_en = 1'b1;
                if (b_flag) begin
                    state_n = STOP;
                end else if (t_cnt == T_PRE && b_cnt < B_ROLL) begin
                    se_n = 1'b1;
                    b_en = 1'b1;
                end
            end
            STOP: begin
                t_en = 1'b1;
                if (t_flag) begin
                    if (rx.serial_in) begin
                        state_n = LOAD;
                        lb_n    = 1'b1;
                        fe_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        fe_n    = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, edge-detect history and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            prev             <= 1'b1;
            rx.shift_enable  <= 1'b0;
            rx.load_buffer   <= 1'b0;
            rx.framing_error <= 1'b0;
            rx.busy          <= 1'b0;
        end else begin
            state            <= state_n;
            prev             <= rx.serial_in;
            rx.shift_enable  <= se_n;
            rx.load_buffer   <= lb_n;
            rx.framing_error <= fe_n;
            rx.busy          <= busy_n;
        end
    end

endmodule

// File: tb/tb_rcv_ctrl_timer.sv
// Scoreboard bench for rcv_ctrl_timer: default instance plus a
// CLKS_PER_BIT=16 / NUM_DATA_BITS=5 instance.
module tb_rcv_ctrl_timer;
    import rcv_pkg::*;

    typedef enum int {K_SE, K_LB, K_FES, K_FEC} kind_t;
    typedef struct {
        kind_t      k;
        int         c;
        logic [7:0] d;
    } exp_t;

    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    exp_t       qa[$];
    exp_t       qb[$];
    int         lb_hist[$];
    logic [7:0] sr[2];
    logic       fe_prev[2];
    logic       fe_model[2];
    int         cpb[2] = '{10, 16};
    int         nbits[2] = '{8, 5};

    rcv_ctrl_timer_if ifa ();
    rcv_ctrl_timer_if ifb ();

    rcv_ctrl_timer u_a (
        .clk  (clk),
        .n_rst(n_rst),
        .rx   (ifa)
    );

    rcv_ctrl_timer #(
        .CLKS_PER_BIT (16),
        .NUM_DATA_BITS(5)
    ) u_b (
        .clk  (clk),
        .n_rst(n_rst),
        .rx   (ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic pop_chk(input int s, input kind_t k,
                           output exp_t e, output bit ok);
        e  = '{K_SE, -1, 8'h00};
        ok = 1'b0;
        if (s == 0 && qa.size() > 0) begin
            e  = qa.pop_front();
            ok = 1'b1;
        end else if (s == 1 && qb.size() > 0) begin
            e  = qb.pop_front();
            ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL event_dut%0d: got %s@%0d want nothing",
                     s, k.name(), cyc);
        end else if (e.k != k || e.c != cyc) begin
            fails++;
            $display("FAIL event_dut%0d: got %s@%0d want %s@%0d",
                     s, k.name(), cyc, e.k.name(), e.c);
        end
    endtask

    task automatic mon(input int s, input logic se, input logic lb,
                       input logic fe, input logic sin);
        exp_t e;
        bit   ok;
        if (fe !== fe_prev[s]) begin
            pop_chk(s, fe ? K_FES : K_FEC, e, ok);
            fe_prev[s] = fe;
        end
        if (se) begin
            pop_chk(s, K_SE, e, ok);
            sr[s] = {sin, sr[s][7:1]};
        end
        if (lb) begin
            pop_chk(s, K_LB, e, ok);
            if (ok) begin
                chk($sformatf("data_dut%0d", s),
                    int'(sr[s] >> (8 - nbits[s])), int'(e.d));
            end
            if (s == 0) lb_hist.push_back(cyc);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            mon(0, ifa.shift_enable, ifa.load_buffer,
                ifa.framing_error, ifa.serial_in);
            mon(1, ifb.shift_enable, ifb.load_buffer,
                ifb.framing_error, ifb.serial_in);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic v);
        if (s == 0) ifa.serial_in = v;
        else ifb.serial_in = v;
    endtask

    task automatic push(input int s, input exp_t e);
        if (s == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    // Drives one frame starting in the current cycle; expectations
    // are only queued for events that fall before the cut offset.
    task automatic send_frame(input int s, input logic [7:0] d,
                              input logic stop, input int cut);
        int   c, n, h, t0, total, b, oc;
        logic v;
        c     = cpb[s];
        n     = nbits[s];
        h     = c / 2;
        t0    = cyc;
        total = (n + 2) * c;
        if (fe_model[s] && (h + 1) < cut) push(s, '{K_FEC, t0 + h + 1, d});
        fe_model[s] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (h + (k + 1) * c < cut) push(s, '{K_SE, t0 + h + (k + 1) * c, d});
        end
        oc = h + (n + 1) * c + 1;
        if (oc < cut) begin
            if (stop) begin
                push(s, '{K_LB, t0 + oc, d});
            end else begin
                push(s, '{K_FES, t0 + oc, d});
                fe_model[s] = 1'b1;
            end
        end
        for (int o = 0; o < total && o < cut; o++) begin
            b = o / c;
            if (b == 0) v = 1'b0;
            else if (b <= n) v = d[b-1];
            else v = stop;
            drive(s, v);
            wait_cyc(1);
        end
    endtask

    initial begin
        ifa.serial_in = 1'b1;
        ifb.serial_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sr[i]       = 8'h00;
            fe_prev[i]  = 1'b0;
            fe_model[i] = 1'b0;
        end
        wait_cyc(3);
        chk("rst_se", ifa.shift_enable, 0);
        chk("rst_lb", ifa.load_buffer, 0);
        chk("rst_fe", ifa.framing_error, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_busy_b", ifb.busy, 0);
        n_rst = 1'b1;
        wait_cyc(5);

        send_frame(0, 8'hA5, 1'b1, BIG);
        drive(0, 1'b1);
        wait_cyc(5);
        chk("a5_fe", ifa.framing_error, 0);

        drive(0, 1'b0);
        wait_cyc(1);
        chk("fs_busy_c1", ifa.busy, 1);
        wait_cyc(1);
        drive(0, 1'b1);
        wait_cyc(3);
        chk("fs_busy_c5", ifa.busy, 1);
        wait_cyc(1);
        chk("fs_idle_c6", ifa.busy, 0);
        wait_cyc(5);

        send_frame(0, 8'h3C, 1'b0, BIG);
        wait_cyc(30);
        chk("break_idle", ifa.busy, 0);
        chk("fe_sticky", ifa.framing_error, 1);
        drive(0, 1'b1);
        wait_cyc(5);
        send_frame(0, 8'h00, 1'b1, BIG);
        chk("fe_cleared", ifa.framing_error, 0);
        drive(0, 1'b1);
        wait_cyc(5);

        send_frame(0, 8'h55, 1'b1, BIG);
        send_frame(0, 8'hFF, 1'b1, BIG);
        drive(0, 1'b1);
        wait_cyc(5);
        chk("lb_count", lb_hist.size(), 4);
        if (lb_hist.size() >= 2) begin
            chk("b2b_gap", lb_hist[lb_hist.size()-1] -
                lb_hist[lb_hist.size()-2], 100);
        end
        wait_cyc(5);

        send_frame(0, 8'h99, 1'b1, 40);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_se", ifa.shift_enable, 0);
        chk("mid_rst_lb", ifa.load_buffer, 0);
        chk("mid_rst_fe", ifa.framing_error, 0);
        chk("mid_rst_busy", ifa.busy, 0);
        qa.delete();
        fe_model[0] = 1'b0;
        fe_prev[0]  = 1'b0;
        fe_prev[1]  = 1'b0;
        drive(0, 1'b1);
        wait_cyc(3);
        n_rst = 1'b1;
        wait_cyc(5);
        chk("post_rst_busy", ifa.busy, 0);
        send_frame(0, 8'hC3, 1'b1, BIG);
        drive(0, 1'b1);
        wait_cyc(5);

        send_frame(1, 8'h13, 1'b1, BIG);
        drive(1, 1'b1);
        wait_cyc(10);
        chk("b_fe", ifb.framing_error, 0);

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
